// File: rtl/truth_table_sweeper_if.sv
// Config, direct-lookup and row-stream signals of the truth-table sweeper.
// The slave modport is the sweeper's side; master is the driver/sink side.
interface truth_table_sweeper_if #(
  parameter int unsigned N_IN  = 4,
  parameter int unsigned N_OUT = 10
);
   logic             cfg_we;
   logic [N_IN-1:0]  cfg_addr;
   logic [N_OUT-1:0] cfg_data;
   logic [N_IN-1:0]  in_vec;
   logic [N_OUT-1:0] out_vec;
   logic             start;
   logic             row_valid;
   logic             row_ready;
   logic [N_IN-1:0]  row_idx;
   logic [N_OUT-1:0] row_out;
   logic             row_mark;
   logic             row_last;
   logic             busy;
   logic             done;

   modport master (
      output cfg_we, cfg_addr, cfg_data, in_vec, start, row_ready,
      input  out_vec, row_valid, row_idx, row_out, row_mark, row_last, busy, done
   );

   modport slave (
      input  cfg_we, cfg_addr, cfg_data, in_vec, start, row_ready,
      output out_vec, row_valid, row_idx, row_out, row_mark, row_last, busy, done
   );
endinterface

// File: rtl/truth_table_sweeper.sv
// Programmable truth table: registered direct lookup plus an autonomous sweep
// that streams every {index, outputs, group marker} row over valid/ready.
module truth_table_sweeper #(
   parameter int unsigned N_IN  = 4,
   parameter int unsigned N_OUT = 10,
   parameter int unsigned GROUP = 4
) (
   input logic                   clk,
   input logic                   rst,
   truth_table_sweeper_if.slave  bus
);

   localparam int unsigned      Rows      = 2 ** N_IN;
   localparam logic [N_IN-1:0]  GroupMask = N_IN'(GROUP - 1);
   localparam logic [N_IN:0]    LastIdx   = (N_IN + 1)'(Rows - 1);

   typedef enum logic [1:0] {StIdle, StSweep, StDone} state_e;

   state_e           state_q;
   logic [N_OUT-1:0] lut_q [Rows];
   logic [N_OUT-1:0] out_vec_q;
   logic [N_IN:0]    cnt_q;
   logic [N_IN:0]    load_idx;
   logic [N_IN-1:0]  load_row;
   logic             row_valid_q, row_mark_q, row_last_q, busy_q, done_q;
   logic [N_IN-1:0]  row_idx_q;
   logic [N_OUT-1:0] row_out_q;
   logic             lut_we, handshake;

   // Counter is one bit wider than the index so the terminal compare never wraps.
   always_comb begin
      load_idx  = (state_q == StIdle) ? '0 : cnt_q + 1'b1;
      load_row  = load_idx[N_IN-1:0];
      lut_we    = bus.cfg_we && (state_q == StIdle);
      handshake = row_valid_q && bus.row_ready;
   end

   // Nonblocking read of the old row gives read-before-write on a colliding cfg_we.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lut_q     <= '{default: '0};
         out_vec_q <= '0;
      end else begin
         out_vec_q <= lut_q[bus.in_vec];
         if (lut_we) lut_q[bus.cfg_addr] <= bus.cfg_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         row_valid_q <= 1'b0;
         row_idx_q   <= '0;
         row_out_q   <= '0;
         row_mark_q  <= 1'b0;
         row_last_q  <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               done_q <= 1'b0;
               if (bus.start) begin
                  state_q     <= StSweep;
                  row_valid_q <= 1'b1;
                  busy_q      <= 1'b1;
                  cnt_q       <= load_idx;
                  row_idx_q   <= load_row;
                  row_out_q   <= lut_q[load_row];
                  row_mark_q  <= (load_row & GroupMask) == GroupMask;
                  row_last_q  <= load_idx == LastIdx;
               end
            end
            StSweep: begin
               if (handshake) begin
                  if (row_last_q) begin
                     state_q     <= StDone;
                     row_valid_q <= 1'b0;
                     busy_q      <= 1'b0;
                     done_q      <= 1'b1;
                  end else begin
                     cnt_q      <= load_idx;
                     row_idx_q  <= load_row;
                     row_out_q  <= lut_q[load_row];
                     row_mark_q <= (load_row & GroupMask) == GroupMask;
                     row_last_q <= load_idx == LastIdx;
                  end
               end
            end
            StDone: begin
               done_q  <= 1'b0;
               state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign bus.out_vec   = out_vec_q;
   assign bus.row_valid = row_valid_q;
   assign bus.row_idx   = row_idx_q;
   assign bus.row_out   = row_out_q;
   assign bus.row_mark  = row_mark_q;
   assign bus.row_last  = row_last_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper: default 4/10/4 instance plus a 3/2/2 variant.
module tb_truth_table_sweeper;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   truth_table_sweeper_if #(.N_IN(4), .N_OUT(10)) bus_a ();
   truth_table_sweeper_if #(.N_IN(3), .N_OUT(2))  bus_b ();

   truth_table_sweeper #(.N_IN(4), .N_OUT(10), .GROUP(4)) dut_a (
      .clk (clk),
      .rst (rst),
      .bus (bus_a)
   );

   truth_table_sweeper #(.N_IN(3), .N_OUT(2), .GROUP(2)) dut_b (
      .clk (clk),
      .rst (rst),
      .bus (bus_b)
   );

   int total = 0;
   int bad   = 0;
   logic [9:0] exp_lut [16];

   function automatic logic [9:0] model_row(input int i);
      logic [3:0] v;
      logic w, x, y, z, f2, f3;
      v = 4'(i);
      w = v[3]; x = v[2]; y = v[1]; z = v[0];
      f2 = (z & w & x) | (y & w & x) | (y & z & w) | (y & z & x);
      f3 = (y & x) | (z & w);
      return {6'b0, f3, f2, 2'b00};
   endfunction

   task automatic init_inputs();
      bus_a.cfg_we = 0; bus_a.cfg_addr = '0; bus_a.cfg_data = '0;
      bus_a.in_vec = '0; bus_a.start = 0; bus_a.row_ready = 0;
      bus_b.cfg_we = 0; bus_b.cfg_addr = '0; bus_b.cfg_data = '0;
      bus_b.in_vec = '0; bus_b.start = 0; bus_b.row_ready = 0;
      for (int i = 0; i < 16; i++) exp_lut[i] = '0;
   endtask

   // mode 0: full rate, 1: ready pattern 1,0,0,1, 2: cfg write + start while busy
   task automatic test_sweep(input int mode, input string tag);
      int exp_idx = 0;
      int busy_cyc = 0;
      int cyc = 0;
      int exp_cyc;
      bit stalled = 0;
      bit rdy;
      logic [15:0] held = '0;
      exp_cyc = (mode == 1) ? 32 : 16;
      @(negedge clk) bus_a.start = 1;
      @(negedge clk) bus_a.start = 0;
      while (exp_idx < 16 && cyc < 200) begin
         rdy = (mode == 1) ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
         bus_a.row_ready = rdy;
         if (mode == 2 && cyc == 2) begin
            bus_a.cfg_we = 1; bus_a.cfg_addr = 4'd9; bus_a.cfg_data = 10'h3FF;
            bus_a.start = 1;
         end else begin
            bus_a.cfg_we = 0; bus_a.start = 0;
         end
         if (bus_a.busy) busy_cyc++;
         total++;
         if (bus_a.row_valid !== 1'b1) begin
            bad++; $display("FAIL %s valid idx%0d: got %b want 1", tag, exp_idx, bus_a.row_valid);
         end
         if (stalled) begin
            total++;
            if ({bus_a.row_idx, bus_a.row_out, bus_a.row_mark, bus_a.row_last} !== held) begin
               bad++;
               $display("FAIL %s stall_hold: got %h want %h", tag,
                        {bus_a.row_idx, bus_a.row_out, bus_a.row_mark, bus_a.row_last}, held);
            end
         end
         total++;
         if (bus_a.row_idx !== 4'(exp_idx)) begin
            bad++; $display("FAIL %s row_idx: got %0d want %0d", tag, bus_a.row_idx, exp_idx);
         end
         total++;
         if (bus_a.row_out !== exp_lut[exp_idx]) begin
            bad++;
            $display("FAIL %s row_out idx%0d: got %h want %h", tag, exp_idx, bus_a.row_out,
                     exp_lut[exp_idx]);
         end
         total++;
         if (bus_a.row_mark !== (exp_idx % 4 == 3)) begin
            bad++; $display("FAIL %s row_mark idx%0d: got %b", tag, exp_idx, bus_a.row_mark);
         end
         total++;
         if (bus_a.row_last !== (exp_idx == 15)) begin
            bad++; $display("FAIL %s row_last idx%0d: got %b", tag, exp_idx, bus_a.row_last);
         end
         stalled = !rdy;
         held = {bus_a.row_idx, bus_a.row_out, bus_a.row_mark, bus_a.row_last};
         if (rdy) exp_idx++;
         cyc++;
         @(negedge clk);
      end
      bus_a.row_ready = 0; bus_a.cfg_we = 0; bus_a.start = 0;
      total++;
      if (exp_idx != 16) begin
         bad++; $display("FAIL %s timeout: got %0d rows want 16", tag, exp_idx);
      end
      total++;
      if ({bus_a.done, bus_a.row_valid, bus_a.busy} !== 3'b100) begin
         bad++;
         $display("FAIL %s end_flags {done,valid,busy}: got %b want 100", tag,
                  {bus_a.done, bus_a.row_valid, bus_a.busy});
      end
      total++;
      if (busy_cyc != exp_cyc || cyc != exp_cyc) begin
         bad++;
         $display("FAIL %s busy_cycles: got %0d/%0d want %0d", tag, busy_cyc, cyc, exp_cyc);
      end
      @(negedge clk);
      total++;
      if (bus_a.done !== 1'b0 || bus_a.row_valid !== 1'b0) begin
         bad++; $display("FAIL %s done_pulse_width: got done=%b want 0", tag, bus_a.done);
      end
   endtask

   task automatic test_reset();
      #12;
      total++;
      if ({bus_a.out_vec, bus_a.row_valid, bus_a.row_idx, bus_a.row_out, bus_a.row_mark,
           bus_a.row_last, bus_a.busy, bus_a.done} !== '0) begin
         bad++; $display("FAIL reset_initial: outputs not zero (out_vec=%h)", bus_a.out_vec);
      end
      @(negedge clk) rst = 0;
      // Program rows 0..3 and stall the sweep on row 3 so every field is non-zero.
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         bus_a.cfg_we = 1; bus_a.cfg_addr = 4'(i); bus_a.cfg_data = 10'h155;
      end
      @(negedge clk) bus_a.cfg_we = 0; bus_a.in_vec = 4'd3; bus_a.start = 1;
      @(negedge clk) bus_a.start = 0; bus_a.row_ready = 1;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk) bus_a.row_ready = 0;
      total++;
      if (bus_a.row_idx !== 4'd3 || bus_a.row_out !== 10'h155 || bus_a.out_vec !== 10'h155) begin
         bad++;
         $display("FAIL reset_pre: got idx=%0d out=%h vec=%h want 3/155/155",
                  bus_a.row_idx, bus_a.row_out, bus_a.out_vec);
      end
      #2 rst = 1;
      #1;
      total++; if (bus_a.out_vec !== '0) begin bad++; $display("FAIL rst_out_vec: got %h want 0", bus_a.out_vec); end
      total++; if (bus_a.row_valid !== 1'b0) begin bad++; $display("FAIL rst_row_valid: got %b want 0", bus_a.row_valid); end
      total++; if (bus_a.row_idx !== '0) begin bad++; $display("FAIL rst_row_idx: got %h want 0", bus_a.row_idx); end
      total++; if (bus_a.row_out !== '0) begin bad++; $display("FAIL rst_row_out: got %h want 0", bus_a.row_out); end
      total++; if (bus_a.row_mark !== 1'b0) begin bad++; $display("FAIL rst_row_mark: got %b want 0", bus_a.row_mark); end
      total++; if (bus_a.row_last !== 1'b0) begin bad++; $display("FAIL rst_row_last: got %b want 0", bus_a.row_last); end
      total++; if (bus_a.busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", bus_a.busy); end
      total++; if (bus_a.done !== 1'b0) begin bad++; $display("FAIL rst_done: got %b want 0", bus_a.done); end
      @(negedge clk) rst = 0;
      @(negedge clk);
      total++;
      if (bus_a.out_vec !== '0) begin
         bad++; $display("FAIL rst_lut_cleared: got %h want 0", bus_a.out_vec);
      end
      test_sweep(0, "post_reset");
   endtask

   task automatic test_program_direct();
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         exp_lut[i] = model_row(i);
         bus_a.cfg_we = 1; bus_a.cfg_addr = 4'(i); bus_a.cfg_data = exp_lut[i];
      end
      @(negedge clk) bus_a.cfg_we = 0; bus_a.in_vec = 4'd15;
      @(negedge clk);
      total++; if (bus_a.out_vec !== 10'h00C) begin bad++; $display("FAIL direct_15: got %h want 00c", bus_a.out_vec); end
      bus_a.in_vec = 4'd6;
      @(negedge clk);
      total++; if (bus_a.out_vec !== 10'h008) begin bad++; $display("FAIL direct_6: got %h want 008", bus_a.out_vec); end
      bus_a.in_vec = 4'd5;
      bus_a.cfg_we = 1; bus_a.cfg_addr = 4'd5; bus_a.cfg_data = 10'h2AA;
      @(negedge clk) bus_a.cfg_we = 0;
      total++; if (bus_a.out_vec !== 10'h000) begin bad++; $display("FAIL direct_5_rbw_old: got %h want 000", bus_a.out_vec); end
      @(negedge clk);
      total++; if (bus_a.out_vec !== 10'h2AA) begin bad++; $display("FAIL direct_5_rbw_new: got %h want 2aa", bus_a.out_vec); end
      bus_a.cfg_we = 1; bus_a.cfg_data = 10'h000;
      @(negedge clk) bus_a.cfg_we = 0;
   endtask

   task automatic test_full_rate();
      test_sweep(0, "full_rate");
   endtask

   task automatic test_backpressure();
      test_sweep(1, "backpressure");
   endtask

   task automatic test_busy_config();
      test_sweep(2, "busy_cfg");
      bus_a.in_vec = 4'd9;
      @(negedge clk);
      @(negedge clk);
      total++;
      if (bus_a.out_vec !== 10'h008) begin
         bad++; $display("FAIL busy_cfg_row9: got %h want 008", bus_a.out_vec);
      end
   endtask

   task automatic test_reset_mid_sweep();
      bit found = 0;
      bus_a.row_ready = 1;
      @(negedge clk) bus_a.start = 1;
      @(negedge clk) bus_a.start = 0;
      for (int c = 0; c < 40; c++) begin
         if (bus_a.row_valid && bus_a.row_idx == 4'd7) begin
            found = 1;
            break;
         end
         @(negedge clk);
      end
      total++;
      if (!found) begin bad++; $display("FAIL mid_reset_reach7: got no idx 7 want idx 7"); end
      #2 rst = 1;
      #1;
      total++;
      if ({bus_a.row_valid, bus_a.busy, bus_a.done} !== 3'b000) begin
         bad++;
         $display("FAIL mid_reset_flags: got %b want 000", {bus_a.row_valid, bus_a.busy, bus_a.done});
      end
      bus_a.row_ready = 0;
      @(negedge clk) rst = 0;
      @(negedge clk);
      total++;
      if (bus_a.done !== 1'b0) begin bad++; $display("FAIL mid_reset_no_done: got %b want 0", bus_a.done); end
      for (int i = 0; i < 16; i++) exp_lut[i] = '0;
      test_sweep(0, "after_abort");
   endtask

   task automatic test_param_variant();
      logic [1:0] exp_b [8];
      int exp_idx = 0;
      int cyc = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         exp_b[i] = 2'(i * 3 + 1);
         bus_b.cfg_we = 1; bus_b.cfg_addr = 3'(i); bus_b.cfg_data = exp_b[i];
      end
      @(negedge clk) bus_b.cfg_we = 0; bus_b.row_ready = 1; bus_b.start = 1;
      @(negedge clk) bus_b.start = 0;
      while (exp_idx < 8 && cyc < 50) begin
         total++;
         if (bus_b.row_valid !== 1'b1 || bus_b.row_idx !== 3'(exp_idx) ||
             bus_b.row_out !== exp_b[exp_idx]) begin
            bad++;
            $display("FAIL var_row%0d: got v=%b idx=%0d out=%h want 1/%0d/%h", exp_idx,
                     bus_b.row_valid, bus_b.row_idx, bus_b.row_out, exp_idx, exp_b[exp_idx]);
         end
         total++;
         if (bus_b.row_mark !== (exp_idx % 2 == 1) || bus_b.row_last !== (exp_idx == 7)) begin
            bad++;
            $display("FAIL var_flags%0d: got mark=%b last=%b", exp_idx, bus_b.row_mark,
                     bus_b.row_last);
         end
         exp_idx++;
         cyc++;
         @(negedge clk);
      end
      bus_b.row_ready = 0;
      total++;
      if (exp_idx != 8 || bus_b.done !== 1'b1 || bus_b.busy !== 1'b0) begin
         bad++;
         $display("FAIL var_end: got rows=%0d done=%b busy=%b want 8/1/0", exp_idx, bus_b.done,
                  bus_b.busy);
      end
   endtask

   initial begin
      init_inputs();
      test_reset();
      test_program_direct();
      test_full_rate();
      test_backpressure();
      test_busy_config();
      test_reset_mid_sweep();
      test_param_variant();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/truth_table_sweeper.md
Name: truth_table_sweeper

Overview:
- Parametrised, clocked successor to the fixed 4-input/10-output combinational breadboard.
- Holds a programmable lookup table of 2^N_IN rows × N_OUT output bits, written through a config port.
- Direct mode: a registered lookup of an applied input vector.
- Sweep mode: autonomously steps through every input combination and streams {index, outputs, group marker} rows to a downstream printer/checker over a valid/ready handshake, replacing hand-written testbench loops.

Parameters:
- N_IN, 4, number of function inputs; bit N_IN-1 is the high input (w), bit 0 is the low input (z).
- N_OUT, 10, number of function outputs (f0..f(N_OUT-1)); bit k = fk.
- GROUP, 4, row_mark asserted on rows where idx % GROUP == GROUP-1; must be a power of two ≤ 2^N_IN.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- cfg_we  in  1  write LUT row cfg_addr with cfg_data
- cfg_addr  in  N_IN  LUT row to write
- cfg_data  in  N_OUT  output vector for that row
- in_vec  in  N_IN  direct-mode input {w,x,y,...,z}
- out_vec  out  N_OUT  registered LUT[in_vec]
- start  in  1  begin sweep (level sampled; one cycle is sufficient)
- row_valid  out  1  sweep row available
- row_ready  in  1  sink accepts row
- row_idx  out  N_IN  row index (= input vector of the row)
- row_out  out  N_OUT  LUT[row_idx]
- row_mark  out  1  last row of a GROUP block
- row_last  out  1  final row (idx = 2^N_IN-1)
- busy  out  1  sweep in progress
- done  out  1  one-cycle pulse after final row accepted

Behaviour:
- Reset (asynchronous, rst=1)
  - All LUT rows → 0.
  - out_vec, row_valid, row_idx, row_out, row_mark, row_last, busy, done → 0.
  - FSM → IDLE.
  - Reset asserted mid-sweep aborts the sweep immediately; no done pulse.
- LUT storage: a flop array (2^N_IN × N_OUT).
  - cfg_we is honoured only in IDLE. It is ignored (no write) while busy=1 or in DONE.
- Direct path
  - out_vec <= LUT[in_vec] every cycle, in all states: 1-cycle latency.
  - Read-before-write: if cfg_we targets the row being read in the same cycle, out_vec shows the old value; the new value appears on the next cycle.
- FSM states: IDLE, SWEEP, DONE.
  - IDLE → SWEEP when start=1. In that same edge: idx=0, row_valid=1, busy=1, row fields loaded for row 0. The first row is valid on the cycle after start.
  - SWEEP
    - While row_valid=1 and row_ready=0, row_idx, row_out, row_mark and row_last are held stable.
    - Handshake occurs when row_valid & row_ready are both 1.
    - On a handshake with row_last=0: the next row is loaded at the same edge; row_valid stays 1. Back-to-back acceptance gives 1 row per cycle.
    - On a handshake with row_last=1: → DONE; row_valid=0, busy=0.
  - DONE: done=1 for exactly one cycle, then → IDLE.
  - start is ignored in SWEEP and DONE, and does not restart the sweep.
- Row field rules
  - row_out = LUT[row_idx], sampled at the load edge.
  - row_mark = (row_idx & (GROUP-1)) == GROUP-1.
  - row_last = (row_idx == 2^N_IN-1).
- Widths
  - The internal counter is N_IN+1 bits, so the terminal compare never relies on N_IN-bit wrap.
  - row_idx is the low N_IN bits of the counter.
- Total handshakes per sweep = 2^N_IN exactly. No row is skipped or duplicated under any row_ready pattern.
- Combinational idle outputs: row_valid=0; row fields keep their last values (don't-care for the sink).

Test Plan:
- Reset check
  - Stimulus: assert rst mid-cycle.
  - Required: every output 0 asynchronously, before the next clk edge. A sweep started afterwards returns row_out=0 for all 16 rows.
- Program f2/f3 functions, direct read
  - Stimulus: write all 16 rows with f2 = zwx|ywx|yzw|yzx at bit 2 and f3 = yx|zw at bit 3. Then drive in_vec=15, 6, 5.
  - Required: out_vec = 10'h00C, 10'h008, 10'h000 respectively, each one cycle after its in_vec.
- Full-rate sweep
  - Stimulus: row_ready held at 1; pulse start.
  - Required: 16 consecutive valid cycles with row_idx 0..15.
  - Required: row_mark at idx 3, 7, 11, 15; row_last only at 15.
  - Required: done pulses the cycle after idx 15 is accepted; busy is high for exactly 16 cycles.
- Backpressure
  - Stimulus: row_ready toggles 1,0,0,1,…
  - Required: row fields stay stable while stalled.
  - Required: exactly 16 handshakes, indices strictly increasing by 1.
- Config/start while busy
  - Stimulus: during a sweep, cfg_we=1 with addr=9, data=10'h3FF, plus a second start pulse.
  - Required: LUT row 9 is unchanged (row_out and later out_vec show the original value); the sweep is not restarted.
- Reset mid-sweep and parameter variant
  - Stimulus: assert rst at idx 7.
  - Required: row_valid, busy and done go to 0; a fresh start restarts at idx 0.
  - Stimulus: repeat the full-rate sweep with N_IN=3, N_OUT=2, GROUP=2.
  - Required: 8 rows, row_mark at odd idx, row_last at idx 7.
